if_fetch_stage: RTL and testbench

//  Instruction-fetch stage and IF/ID pipeline register; sits directly upstream of hazard_unit.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/if_fetch_stage_if.sv | 34 +++
 rtl/if_id_reg.sv | 52 +++++
 rtl/if_fetch_stage.sv | 135 +++++++++++++
 tb/tb_if_fetch_stage.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch slice.
//   XLEN          : PC / address width used by the packed fetch entry
//   NOP_INSTR     : addi x0,x0,0, shown in IF/ID after reset
//   fetch_state_e : request FSM states (REQ issue, WAIT response, DROP stale)
//   fetch_entry_t : {pc, instr} pair held by the skid buffer and IF/ID
//   next_pc       : sequential PC step, wraps modulo 2^XLEN
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bundle.
//   req_valid  : fetch request valid            (master -> slave)
//   req_ready  : memory accepts request         (slave -> master)
//   req_addr   : fetch address                  (master -> slave)
//   resp_valid : response valid, >=1 cycle after acceptance (slave -> master)
//   resp_data  : fetched instruction            (slave -> master)
// master = fetch stage, slave = instruction memory.
interface if_fetch_stage_if #(
  parameter int XLEN = 32
);

  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            resp_valid;
  logic [31:0]     resp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  resp_valid,
    input  resp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output resp_valid,
    output resp_data
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: valid flag plus {pc, instr}.
//   clk, rst      : clock, synchronous active-high reset
//   flush         : kill the held instruction (highest priority)
//   hold          : keep valid/pc/instr unchanged
//   load          : capture load_entry as a live instruction
//   load_entry    : {pc, instr} to capture
//   if_id_valid   : register holds a live instruction
//   if_id_pc      : pc of the held instruction
//   if_id_instr   : held instruction
// With none of flush/hold/load the register turns into a bubble.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            hold,
  input  logic            load,
  input  fetch_entry_t    load_entry,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_instr
);

  logic         vld_p1;
  fetch_entry_t entry_p1;

  // IF -> ID boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1         <= 1'b0;
      entry_p1.pc    <= RESET_PC;
      entry_p1.instr <= NOP_INSTR;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (hold) begin
      vld_p1 <= vld_p1;
    end else if (load) begin
      vld_p1   <= 1'b1;
      entry_p1 <= load_entry;
    end else begin
      vld_p1 <= 1'b0;
    end
  end

  assign if_id_valid = vld_p1;
  assign if_id_pc    = entry_p1.pc;
  assign if_id_instr = entry_p1.instr;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with IF/ID register, upstream of hazard_unit.
//   clk, rst        : clock, synchronous active-high reset
//   imem            : instruction-memory master port (one request outstanding)
//   stall           : hold IF/ID (decode not consuming)
//   redirect_valid  : flush fetch and restart at redirect_pc
//   redirect_pc     : redirect target
//   if_id_valid     : IF/ID holds a live instruction
//   if_id_pc        : pc of the IF/ID instruction
//   if_id_instr     : IF/ID instruction
// A response that cannot enter IF/ID because of a stall parks in a one-entry
// skid buffer; no request is issued while the skid is full or filling, so the
// skid can never overflow. After a redirect the outstanding response (if not
// already back) is tracked in DROP and discarded when it arrives.
module if_fetch_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  if_fetch_stage_if.master        imem,
  input  logic                    stall,
  input  logic                    redirect_valid,
  input  logic [XLEN-1:0]         redirect_pc,
  output logic                    if_id_valid,
  output logic [XLEN-1:0]         if_id_pc,
  output logic [31:0]             if_id_instr
);

  import fetch_pkg::*;

  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;
  logic            skid_full;
  fetch_entry_t    skid;

  logic            ifid_free;
  logic            resp_wait;
  logic            req_valid;
  logic            accept;
  logic            skid_fill;
  logic            ifid_load;
  logic            ifid_hold;
  fetch_entry_t    resp_entry;
  fetch_entry_t    ifid_entry;

  assign ifid_free = !if_id_valid || !stall;
  assign resp_wait = (state == WAIT) && imem.resp_valid;
  assign accept    = req_valid && imem.req_ready;
  // A response that decode cannot take goes to the skid, unless redirected away.
  assign skid_fill = resp_wait && !ifid_free && !redirect_valid;

  // Request issue: in WAIT a new request rides on the response cycle only if
  // that response goes straight into IF/ID (skid stays empty).
  always_comb begin
    req_valid = 1'b0;
    if (!rst && !redirect_valid) begin
      case (state)
        REQ:     req_valid = !skid_full;
        WAIT:    req_valid = imem.resp_valid && ifid_free;
        default: req_valid = 1'b0;
      endcase
    end
  end

  assign imem.req_valid = req_valid;
  assign imem.req_addr  = pc;

  always_comb begin
    state_nxt = state;
    case (state)
      REQ: begin
        if (accept) state_nxt = WAIT;
      end
      WAIT: begin
        if (redirect_valid)      state_nxt = imem.resp_valid ? REQ : DROP;
        else if (imem.resp_valid) state_nxt = accept ? WAIT : REQ;
      end
      DROP: begin
        // The stale response is the only thing that can end DROP, even if a
        // further redirect lands in the same cycle.
        if (imem.resp_valid) state_nxt = REQ;
      end
      default: state_nxt = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= REQ;
      pc        <= RESET_PC;
      skid_full <= 1'b0;
    end else begin
      state <= state_nxt;
      if (redirect_valid) pc <= redirect_pc;
      else if (accept)    pc <= next_pc(pc);
      if (redirect_valid)            skid_full <= 1'b0;
      else if (skid_full && ifid_free) skid_full <= 1'b0;
      else if (skid_fill)            skid_full <= 1'b1;
    end
  end

  // req_pc tags the single outstanding request with its address.
  always_ff @(posedge clk) begin
    if (accept) req_pc <= pc;
    if (skid_fill) begin
      skid.pc    <= req_pc;
      skid.instr <= imem.resp_data;
    end
  end

  always_comb begin
    resp_entry.pc    = req_pc;
    resp_entry.instr = imem.resp_data;
    ifid_entry       = skid_full ? skid : resp_entry;
  end

  assign ifid_hold = stall && if_id_valid;
  assign ifid_load = skid_full || resp_wait;

  if_id_reg #(
    .RESET_PC (RESET_PC)
  ) u_if_id_reg (
    .clk         (clk),
    .rst         (rst),
    .flush       (redirect_valid),
    .hold        (ifid_hold),
    .load        (ifid_load),
    .load_entry  (ifid_entry),
    .if_id_valid (if_id_valid),
    .if_id_pc    (if_id_pc),
    .if_id_instr (if_id_instr)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;
  import fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;

  if_fetch_stage_if #(.XLEN(32)) imem ();

  if_fetch_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem           (imem),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_instr    (if_id_instr)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Memory content: each address holds a distinct word derived from it.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h6B3C_91A7;
  endfunction

  // ---------------- instruction memory model ----------------
  int          lat      = 1;
  bit          rdy_zero = 1'b0;
  bit          rdy_rand = 1'b0;
  bit          spur     = 1'b0;
  bit          pend;
  logic [31:0] pend_addr;
  int          cnt;
  bit          acc_s, resp_s, rst_s;
  logic [31:0] addr_s;

  initial begin : mem_model
    imem.req_ready  = 1'b1;
    imem.resp_valid = 1'b0;
    imem.resp_data  = '0;
    pend = 1'b0;
    cnt  = 0;
    pend_addr = '0;
    forever begin
      @(negedge clk);
      acc_s  = imem.req_valid && imem.req_ready;
      addr_s = imem.req_addr;
      resp_s = imem.resp_valid;
      rst_s  = rst;
      @(posedge clk);
      #2;
      if (rst_s) begin
        pend = 1'b0;
      end else begin
        if (resp_s) pend = 1'b0;
        if (acc_s) begin
          checks++;
          if (pend) begin
            failures++;
            $display("FAIL one_outstanding accepted addr=%h while addr=%h pending", addr_s, pend_addr);
          end
          pend = 1'b1;
          pend_addr = addr_s;
          cnt = lat - 1;
        end else if (pend && cnt > 0) begin
          cnt--;
        end
      end
      imem.req_ready = rdy_zero ? 1'b0 : (rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);
      if (spur) begin
        imem.resp_valid = 1'b1;
        imem.resp_data  = 32'hDEAD_BEEF;
      end else begin
        imem.resp_valid = pend && (cnt == 0);
        imem.resp_data  = pend ? instr_of(pend_addr) : 32'h0;
      end
    end
  end

  // ---------------- program-order scoreboard ----------------
  // Decode must see consecutive addresses starting at the last reset/redirect
  // target, each with its memory word, and a held instruction must not change.
  logic [31:0] exp_pc = RST_PC;
  bit          held_prev = 1'b0;
  logic [31:0] last_pc, last_instr;
  int          deliveries = 0;

  initial begin : scoreboard
    last_pc = '0;
    last_instr = '0;
    forever begin
      @(negedge clk);
      if (held_prev) begin
        checks++;
        if (!if_id_valid || if_id_pc !== last_pc || if_id_instr !== last_instr) begin
          failures++;
          $display("FAIL hold_frozen got v=%0b pc=%h instr=%h want v=1 pc=%h instr=%h",
                   if_id_valid, if_id_pc, if_id_instr, last_pc, last_instr);
        end
      end else if (if_id_valid) begin
        checks++;
        if (if_id_pc !== exp_pc || if_id_instr !== instr_of(exp_pc)) begin
          failures++;
          $display("FAIL stream_order got pc=%h instr=%h want pc=%h instr=%h",
                   if_id_pc, if_id_instr, exp_pc, instr_of(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        deliveries++;
      end
      last_pc    = if_id_pc;
      last_instr = if_id_instr;
      held_prev  = if_id_valid && stall && !redirect_valid && !rst;
      if (rst)                 exp_pc = RST_PC;
      else if (redirect_valid) exp_pc = redirect_pc;
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (imem.req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%0b want=0", imem.req_valid); end
    checks++;
    if (if_id_valid !== 1'b0) begin failures++; $display("FAIL reset_if_id_valid got=%0b want=0", if_id_valid); end
    checks++;
    if (if_id_pc !== RST_PC) begin failures++; $display("FAIL reset_if_id_pc got=%h want=%h", if_id_pc, RST_PC); end
    checks++;
    if (if_id_instr !== NOP_INSTR) begin failures++; $display("FAIL reset_if_id_instr got=%h want=%h", if_id_instr, NOP_INSTR); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 3) begin
        checks++;
        if (imem.req_valid !== 1'b1 || imem.req_addr !== 32'(4 * i)) begin
          failures++;
          $display("FAIL seq_addr cycle=%0d got v=%0b addr=%h want v=1 addr=%h", i, imem.req_valid, imem.req_addr, 32'(4 * i));
        end
      end
      checks++;
      if (i < 2) begin
        if (if_id_valid !== 1'b0) begin failures++; $display("FAIL seq_latency cycle=%0d got valid=%0b want=0", i, if_id_valid); end
      end else begin
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'(4 * (i - 2))) begin
          failures++;
          $display("FAIL seq_ifid cycle=%0d got v=%0b pc=%h want v=1 pc=%h", i, if_id_valid, if_id_pc, 32'(4 * (i - 2)));
        end
      end
    end
  endtask

  task automatic test_stall_skid();
    logic [31:0] p, pi;
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    stall = 1'b1;
    @(negedge clk);
    p  = if_id_pc;
    pi = if_id_instr;
    checks++;
    if (if_id_valid !== 1'b1) begin failures++; $display("FAIL stall_pre_valid got=%0b want=1", if_id_valid); end
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      if (k == 3) stall = 1'b0;
      @(negedge clk);
      checks++;
      if (if_id_valid !== 1'b1 || if_id_pc !== p || if_id_instr !== pi) begin
        failures++;
        $display("FAIL stall_frozen k=%0d got v=%0b pc=%h want v=1 pc=%h", k, if_id_valid, if_id_pc, p);
      end
      checks++;
      if (imem.req_valid !== 1'b0) begin failures++; $display("FAIL stall_skid_no_req k=%0d got=%0b want=0", k, imem.req_valid); end
    end
    @(negedge clk);
    checks++;
    if (if_id_valid !== 1'b1 || if_id_pc !== p + 32'd4 || if_id_instr !== instr_of(p + 32'd4)) begin
      failures++;
      $display("FAIL skid_release got v=%0b pc=%h instr=%h want v=1 pc=%h instr=%h",
               if_id_valid, if_id_pc, if_id_instr, p + 32'd4, instr_of(p + 32'd4));
    end
  endtask

  task automatic test_ready_low();
    logic [31:0] a;
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
    rdy_zero = 1'b1;
    @(negedge clk);
    a = imem.req_addr;
    checks++;
    if (imem.req_valid !== 1'b1) begin failures++; $display("FAIL ready_low_valid got=%0b want=1", imem.req_valid); end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (imem.req_valid !== 1'b1 || imem.req_addr !== a) begin
        failures++;
        $display("FAIL ready_low_hold got v=%0b addr=%h want v=1 addr=%h", imem.req_valid, imem.req_addr, a);
      end
    end
    @(posedge clk); #1;
    rdy_zero = 1'b0;
    @(negedge clk);
    checks++;
    if (imem.req_valid !== 1'b1 || imem.req_ready !== 1'b1 || imem.req_addr !== a) begin
      failures++;
      $display("FAIL ready_accept got v=%0b r=%0b addr=%h want v=1 r=1 addr=%h", imem.req_valid, imem.req_ready, imem.req_addr, a);
    end
    @(negedge clk);
    checks++;
    if (imem.req_valid !== 1'b1 || imem.req_addr !== a + 32'd4) begin
      failures++;
      $display("FAIL ready_advance got v=%0b addr=%h want v=1 addr=%h", imem.req_valid, imem.req_addr, a + 32'd4);
    end
  endtask

  task automatic test_redirect();
    bit found;
    lat = 3;
    repeat (8) @(negedge clk);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem.req_valid && imem.req_ready) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin failures++; $display("FAIL redirect_find_accept got=0 want=1"); end
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    @(negedge clk);
    checks++;
    if (imem.req_valid !== 1'b0) begin failures++; $display("FAIL redirect_no_req got=%0b want=0", imem.req_valid); end
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (if_id_valid !== 1'b0) begin failures++; $display("FAIL redirect_flush got=%0b want=0", if_id_valid); end
    checks++;
    if (imem.req_valid !== 1'b0) begin failures++; $display("FAIL redirect_drop_no_req got=%0b want=0", imem.req_valid); end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (imem.req_valid !== 1'b1 || imem.req_addr !== 32'h100) begin
      failures++;
      $display("FAIL redirect_addr got v=%0b addr=%h want v=1 addr=00000100", imem.req_valid, imem.req_addr);
    end
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if_id_valid) begin found = 1'b1; break; end
    end
    checks++;
    if (!found || if_id_pc !== 32'h100) begin
      failures++;
      $display("FAIL redirect_first_pc got found=%0b pc=%h want pc=00000100", found, if_id_pc);
    end
  endtask

  task automatic test_redirect_stall();
    lat = 1;
    repeat (8) @(negedge clk);
    @(posedge clk); #1;
    stall = 1'b1;
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    @(negedge clk);
    checks++;
    if (if_id_valid !== 1'b1) begin failures++; $display("FAIL rs_pre_valid got=%0b want=1", if_id_valid); end
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    checks++;
    if (if_id_valid !== 1'b0) begin failures++; $display("FAIL rs_flush got=%0b want=0", if_id_valid); end
    checks++;
    if (imem.req_valid !== 1'b1 || imem.req_addr !== 32'h200) begin
      failures++;
      $display("FAIL rs_skid_cleared got v=%0b addr=%h want v=1 addr=00000200", imem.req_valid, imem.req_addr);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    lat = 3;
    repeat (8) @(negedge clk);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem.req_valid && imem.req_ready) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin failures++; $display("FAIL rstmid_find_accept got=0 want=1"); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (imem.req_valid !== 1'b0) begin failures++; $display("FAIL rstmid_req_in_rst got=%0b want=0", imem.req_valid); end
    @(posedge clk); #1;
    rst  = 1'b0;
    spur = 1'b1;
    @(negedge clk);
    checks++;
    if (if_id_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%0b want=0", if_id_valid); end
    checks++;
    if (imem.req_valid !== 1'b1 || imem.req_addr !== RST_PC) begin
      failures++;
      $display("FAIL rstmid_addr got v=%0b addr=%h want v=1 addr=%h", imem.req_valid, imem.req_addr, RST_PC);
    end
    @(posedge clk); #1;
    spur = 1'b0;
    @(negedge clk);
    checks++;
    if (if_id_valid !== 1'b0) begin failures++; $display("FAIL rstmid_late_resp got=%0b want=0", if_id_valid); end
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if_id_valid) begin found = 1'b1; break; end
    end
    checks++;
    if (!found || if_id_pc !== RST_PC) begin
      failures++;
      $display("FAIL rstmid_first_pc got found=%0b pc=%h want pc=%h", found, if_id_pc, RST_PC);
    end
  endtask

  task automatic test_wrap();
    bit found;
    lat = 1;
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem.req_valid && imem.req_ready && imem.req_addr == 32'hFFFF_FFFC) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin failures++; $display("FAIL wrap_find_top got=0 want=1"); end
    @(negedge clk);
    checks++;
    if (imem.req_valid !== 1'b1 || imem.req_addr !== 32'h0) begin
      failures++;
      $display("FAIL wrap_addr got v=%0b addr=%h want v=1 addr=00000000", imem.req_valid, imem.req_addr);
    end
  endtask

  task automatic test_random_stream();
    int d0;
    d0 = deliveries;
    rdy_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      stall = ($urandom_range(0, 3) == 0);
      lat   = int'($urandom_range(1, 3));
      if ($urandom_range(0, 39) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = $urandom() & 32'hFFFF_FFFC;
      end else begin
        redirect_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    rdy_rand = 1'b0;
    lat = 1;
    repeat (12) @(negedge clk);
    checks++;
    if (deliveries - d0 < 20) begin
      failures++;
      $display("FAIL random_progress got deliveries=%0d want>=20", deliveries - d0);
    end
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    test_reset();
    test_sequential();
    test_stall_skid();
    test_ready_low();
    test_redirect();
    test_redirect_stall();
    test_reset_mid();
    test_wrap();
    test_random_stream();
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
